// File: rtl/decode_pkg.sv
// decode_pkg: shared constants, destination encodings and D/X control bundle for the decode stage
package decode_pkg;
  localparam logic [15:0] DEF_NOP_INSTR = 16'h0800;
  localparam logic [2:0] DEF_LINK_REG = 3'd7;
  typedef enum logic [1:0] {
    DEST_RT   = 2'b00,
    DEST_RS   = 2'b01,
    DEST_RD   = 2'b10,
    DEST_LINK = 2'b11
  } reg_dest_e;
  typedef struct packed {
    logic valid;
    logic [15:0] instr;
    logic reg_write;
    logic [2:0] write_reg;
  } dx_bundle_t;
endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: 8 x DATA_W 2R1W register file; DECODE_BYPASS_EN forwards same-cycle writeback to reads
module decode_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [2:0]        rs_sel,
  input  logic [2:0]        rt_sel,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);
  logic [DATA_W-1:0] r_regs [8];
  always_ff @(posedge clk)
    if (rst) r_regs <= '{default: '0};
    else if (wb_en) r_regs[wb_sel] <= wb_data;
`ifdef DECODE_BYPASS_EN
  assign rs_data = (wb_en && wb_sel == rs_sel) ? wb_data : r_regs[rs_sel];
  assign rt_data = (wb_en && wb_sel == rt_sel) ? wb_data : r_regs[rt_sel];
`else
  assign rs_data = r_regs[rs_sel];
  assign rt_data = r_regs[rt_sel];
`endif
endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: regfile, RAW/WAW scoreboard, flush squash counter and D/X register (DECODE_BYPASS_EN enables writeback bypass)
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int          DATA_W       = 16,
  parameter int          FLUSH_CYCLES = 3,
  parameter logic [2:0]  LINK_REG     = DEF_LINK_REG,
  parameter logic [15:0] NOP_INSTR    = DEF_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic              ctl_reg_write,
  input  logic [1:0]        ctl_reg_dest,
  input  logic              ctl_zero_ext,
  input  logic              ctl_rs_used,
  input  logic              ctl_rt_used,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm5,
  output logic [DATA_W-1:0] out_imm8,
  output logic [DATA_W-1:0] out_imm11,
  output logic              out_reg_write,
  output logic [2:0]        out_write_reg
);
  localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  logic [CW-1:0] r_flush_cnt;
  logic [7:0] r_sb;
  dx_bundle_t r_dx;
  logic [DATA_W-1:0] r_rs, r_rt, r_imm5, r_imm8, r_imm11;
  logic w_squash, w_hazard, w_accept, w_retire;
  logic [15:0] w_instr;
  logic [2:0] w_rs, w_rt, w_dest;
  logic [7:0] w_clr, w_set, w_dx_mask, w_sb_eff, w_src_busy;
  logic [DATA_W-1:0] w_rs_data, w_rt_data, w_imm5, w_imm8, w_imm11;
  decode_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk(clk),
    .rst(rst),
    .wb_en(wb_en),
    .wb_sel(wb_sel),
    .wb_data(wb_data),
    .rs_sel(w_rs),
    .rt_sel(w_rt),
    .rs_data(w_rs_data),
    .rt_data(w_rt_data)
  );
  assign w_squash = flush || r_flush_cnt != '0;
  assign w_instr = w_squash ? NOP_INSTR : in_instr;
  assign w_rs = w_instr[10:8];
  assign w_rt = w_instr[7:5];
  assign w_dest = ctl_reg_dest == DEST_RT ? w_instr[7:5] :
                  ctl_reg_dest == DEST_RS ? w_instr[10:8] :
                  ctl_reg_dest == DEST_RD ? w_instr[4:2] : LINK_REG;
  assign w_imm5 = {{(DATA_W-5){w_instr[4] & ~ctl_zero_ext}}, w_instr[4:0]};
  assign w_imm8 = {{(DATA_W-8){w_instr[7] & ~ctl_zero_ext}}, w_instr[7:0]};
  assign w_imm11 = {{(DATA_W-11){w_instr[10]}}, w_instr[10:0]};
  assign w_clr = wb_en ? 8'd1 << wb_sel : 8'd0;
  assign w_dx_mask = (r_dx.valid && r_dx.reg_write) ? 8'd1 << r_dx.write_reg : 8'd0;
  // A retiring instruction squashed by a flush never reaches writeback, so it is not tracked
  assign w_retire = r_dx.valid && out_ready && r_dx.reg_write && !flush;
  assign w_set = w_retire ? 8'd1 << r_dx.write_reg : 8'd0;
`ifdef DECODE_BYPASS_EN
  assign w_sb_eff = r_sb & ~w_clr;
  assign w_src_busy = w_sb_eff | w_dx_mask;
`else
  // Without forwarding the write lands only at the edge, so the writeback register still blocks readers
  assign w_sb_eff = r_sb;
  assign w_src_busy = r_sb | w_clr | w_dx_mask;
`endif
  assign w_hazard = (ctl_rs_used && w_src_busy[w_rs]) || (ctl_rt_used && w_src_busy[w_rt]) ||
                    (ctl_reg_write && w_sb_eff[w_dest]);
  assign in_ready = w_squash || (!w_hazard && (!r_dx.valid || out_ready));
  assign w_accept = in_valid && in_ready;
  always_ff @(posedge clk)
    if (rst) begin
      r_dx <= '{valid: 1'b0, instr: NOP_INSTR, reg_write: 1'b0, write_reg: 3'd0};
      r_rs <= '0;
      r_rt <= '0;
      r_imm5 <= '0;
      r_imm8 <= '0;
      r_imm11 <= '0;
    end else if (w_accept) begin
      r_dx <= '{valid: !w_squash, instr: w_instr, reg_write: !w_squash && ctl_reg_write, write_reg: w_dest};
      r_rs <= w_rs_data;
      r_rt <= w_rt_data;
      r_imm5 <= w_imm5;
      r_imm8 <= w_imm8;
      r_imm11 <= w_imm11;
    end else if (w_squash || out_ready) r_dx.valid <= 1'b0;
  always_ff @(posedge clk) begin
    r_sb <= rst ? 8'd0 : (r_sb & ~w_clr) | w_set;
    r_flush_cnt <= rst ? '0 : flush ? CW'(FLUSH_CYCLES - 1) : r_flush_cnt - CW'(r_flush_cnt != '0);
  end
  assign out_valid = r_dx.valid;
  assign out_instr = r_dx.instr;
  assign out_reg_write = r_dx.reg_write;
  assign out_write_reg = r_dx.write_reg;
  assign out_rs_data = r_rs;
  assign out_rt_data = r_rt;
  assign out_imm5 = r_imm5;
  assign out_imm8 = r_imm8;
  assign out_imm11 = r_imm11;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: table vectors, directed corner sequences and random traffic against a reference model
module tb_decode_stage_pipe;
  localparam int DW = 16, FC = 3, NOP = 'h0800;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, ctl_reg_write = 0, ctl_zero_ext = 0;
  logic ctl_rs_used = 0, ctl_rt_used = 0, flush = 0, wb_en = 0, out_valid, out_ready = 1;
  logic out_reg_write;
  logic [15:0] in_instr = 0, out_instr;
  logic [1:0] ctl_reg_dest = 0;
  logic [2:0] wb_sel = 0, out_write_reg;
  logic [DW-1:0] wb_data = 0, out_rs_data, out_rt_data, out_imm5, out_imm8, out_imm11;
  always #5 clk = ~clk;
  decode_stage_pipe #(.DATA_W(DW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .ctl_reg_write(ctl_reg_write), .ctl_reg_dest(ctl_reg_dest), .ctl_zero_ext(ctl_zero_ext),
    .ctl_rs_used(ctl_rs_used), .ctl_rt_used(ctl_rt_used), .flush(flush), .wb_en(wb_en),
    .wb_sel(wb_sel), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
    .out_imm5(out_imm5), .out_imm8(out_imm8), .out_imm11(out_imm11),
    .out_reg_write(out_reg_write), .out_write_reg(out_write_reg)
  );
  int n_cmp = 0, n_err = 0;
  bit last_acc, last_rdy;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct {bit v; int instr, rs, rt, i5, i8, i11; bit rw; int wr;} dx_t;
  int m_regs[8];
  bit m_sb[8];
  int m_cnt;
  dx_t m_dx;
  function automatic int sx(int v, int bits, bit z);
    return (z || v < (1 << (bits - 1))) ? v : v + 65536 - (1 << bits);
  endfunction
  function automatic int fld(int w, int lo);
    return (w >> lo) & 7;
  endfunction
  function automatic int dest(int ins);
    case (ctl_reg_dest)
      2'd0: return fld(ins, 5);
      2'd1: return fld(ins, 8);
      2'd2: return fld(ins, 2);
      default: return 7;
    endcase
  endfunction
  function automatic bit wb_hits(int s);
    return wb_en && int'(wb_sel) == s;
  endfunction
  function automatic bit busy_src(int s);
    bit p;
`ifdef DECODE_BYPASS_EN
    p = m_sb[s] && !wb_hits(s);
`else
    p = m_sb[s] || wb_hits(s);
`endif
    return p || (m_dx.v && m_dx.rw && m_dx.wr == s);
  endfunction
  function automatic bit m_ready();
    int ins = int'(in_instr);
    int d = dest(ins);
    bit haz;
    if (flush || m_cnt > 0) return 1;
    haz = (ctl_rs_used && busy_src(fld(ins, 8))) || (ctl_rt_used && busy_src(fld(ins, 5)));
`ifdef DECODE_BYPASS_EN
    haz = haz || (ctl_reg_write && m_sb[d] && !wb_hits(d));
`else
    haz = haz || (ctl_reg_write && m_sb[d]);
`endif
    return !haz && (!m_dx.v || out_ready);
  endfunction
  function automatic int rd(int s);
`ifdef DECODE_BYPASS_EN
    if (wb_hits(s)) return int'(wb_data);
`endif
    return m_regs[s];
  endfunction
  task automatic step();
    bit rdy, sq, acc, ret;
    int ins, old_wr;
    dx_t nd;
    #2;
    rdy = m_ready();
    last_rdy = in_ready;
    last_acc = in_valid && in_ready;
    if (!rst) check("in_ready", in_ready, rdy);
    sq = flush || m_cnt > 0;
    acc = in_valid && rdy;
    @(posedge clk);
    if (rst) begin
      foreach (m_regs[i]) begin m_regs[i] = 0; m_sb[i] = 0; end
      m_cnt = 0;
      m_dx = '{v: 0, instr: NOP, rs: 0, rt: 0, i5: 0, i8: 0, i11: 0, rw: 0, wr: 0};
    end else begin
      ret = m_dx.v && out_ready && m_dx.rw && !flush;
      old_wr = m_dx.wr;
      ins = sq ? NOP : int'(in_instr);
      nd = '{v: !sq, instr: ins, rs: rd(fld(ins, 8)), rt: rd(fld(ins, 5)), i5: sx(ins & 31, 5, ctl_zero_ext),
             i8: sx(ins & 255, 8, ctl_zero_ext), i11: sx(ins & 2047, 11, 0), rw: !sq && ctl_reg_write, wr: dest(ins)};
      if (acc) m_dx = nd;
      else if (sq || out_ready) m_dx.v = 0;
      if (wb_en) begin m_sb[wb_sel] = 0; m_regs[wb_sel] = int'(wb_data); end
      if (ret) m_sb[old_wr] = 1;
      m_cnt = flush ? FC - 1 : (m_cnt > 0 ? m_cnt - 1 : 0);
    end
    #1;
    check("out_valid", out_valid, m_dx.v);
    check("out_bus", {out_instr, out_rs_data, out_rt_data, out_imm5, out_imm8, out_imm11, out_reg_write, out_write_reg},
          {16'(m_dx.instr), 16'(m_dx.rs), 16'(m_dx.rt), 16'(m_dx.i5), 16'(m_dx.i8), 16'(m_dx.i11), m_dx.rw, 3'(m_dx.wr)});
  endtask
  task automatic set_in(input bit v, input logic [15:0] ins, input bit rw, input logic [1:0] d,
                        input bit z, input bit rsu, input bit rtu);
    in_valid = v; in_instr = ins; ctl_reg_write = rw; ctl_reg_dest = d;
    ctl_zero_ext = z; ctl_rs_used = rsu; ctl_rt_used = rtu;
  endtask
  task automatic wb(input bit en, input logic [2:0] sel, input logic [15:0] data);
    wb_en = en; wb_sel = sel; wb_data = data;
  endtask
  typedef struct {
    logic [15:0] instr;
    logic [1:0] d;
    bit z;
    logic [15:0] rs, rt, i5, i8, i11;
    logic [2:0] wr;
  } vec_t;
  vec_t tbl[5];
  initial begin
    int c;
    logic [127:0] snap;
    tbl[0] = '{16'h0080, 2'b11, 1'b0, 16'h0000, 16'h4444, 16'h0000, 16'hFF80, 16'h0080, 3'd7};
    tbl[1] = '{16'h07FF, 2'b00, 1'b1, 16'h7777, 16'h7777, 16'h001F, 16'h00FF, 16'hFFFF, 3'd7};
    tbl[2] = '{16'h0534, 2'b01, 1'b0, 16'h5555, 16'h1111, 16'hFFF4, 16'h0034, 16'hFD34, 3'd5};
    tbl[3] = '{16'hA2CF, 2'b10, 1'b0, 16'h2222, 16'h6666, 16'h000F, 16'hFFCF, 16'h02CF, 3'd3};
    tbl[4] = '{16'h0310, 2'b10, 1'b1, 16'h3333, 16'h0000, 16'h0010, 16'h0010, 16'h0310, 3'd4};
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_instr", out_instr, 16'h0800);
    rst = 0;
    set_in(1, 16'h07E0, 0, 0, 0, 1, 1);
    step();
    check("rst_regs_read", {out_rs_data, out_rt_data}, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    wb(1, 3, 16'h00A5);
    step();
    wb(0, 0, 0);
    set_in(1, 16'h0300, 0, 0, 0, 1, 0);
    step();
    check("wb_then_read_r3", out_rs_data, 16'h00A5);
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      wb(1, 3'(i), 16'(16'h1111 * i));
      step();
    end
    wb(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      set_in(1, tbl[i].instr, 0, tbl[i].d, tbl[i].z, 1, 1);
      step();
      check($sformatf("tbl%0d", i), {out_rs_data, out_rt_data, out_imm5, out_imm8, out_imm11, out_write_reg},
            {tbl[i].rs, tbl[i].rt, tbl[i].i5, tbl[i].i8, tbl[i].i11, tbl[i].wr});
    end
    set_in(1, 16'h0200, 1, 2'b01, 0, 0, 0);
    step();
    set_in(1, 16'h0200, 0, 2'b00, 0, 1, 0);
    c = 0;
    while (c < 10) begin
      wb(c == 3, 2, 16'hBEEF);
      step();
      if (last_acc) break;
      c++;
    end
    wb(0, 0, 0);
`ifdef DECODE_BYPASS_EN
    check("raw_stall_cycles", c, 3);
`else
    check("raw_stall_cycles", c, 4);
`endif
    check("raw_data", out_rs_data, 16'hBEEF);
    set_in(1, 16'h0400, 1, 2'b01, 0, 0, 0);
    step();
    set_in(1, 16'h0500, 1, 2'b01, 0, 0, 0);
    for (int k = 0; k < FC; k++) begin
      flush = k == 0;
      step();
      check("flush_consumed", last_acc, 1);
      check("flush_out", {out_valid, out_instr, out_reg_write}, {1'b0, 16'h0800, 1'b0});
    end
    flush = 0;
    set_in(1, 16'h04A0, 0, 0, 0, 1, 1);
    step();
    check("flush_no_sb", last_acc, 1);
    check("post_flush_valid", out_valid, 1);
    set_in(1, 16'h0123, 0, 0, 0, 0, 0);
    step();
    snap = {out_valid, out_instr, out_rs_data, out_rt_data, out_imm5, out_imm8, out_imm11};
    out_ready = 0;
    set_in(1, 16'h0456, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("stall_in_ready", last_rdy, 0);
      check("stall_stable", {out_valid, out_instr, out_rs_data, out_rt_data, out_imm5, out_imm8, out_imm11}, snap);
    end
    out_ready = 1;
    for (int k = 0; k < 600; k++) begin
      rst = $urandom_range(0, 99) == 0;
      set_in($urandom_range(0, 9) < 7, 16'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom));
      flush = $urandom_range(0, 19) == 0;
      wb($urandom_range(0, 9) < 4, 3'($urandom), 16'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
